// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue controller: datapath width,
// opcodes, instruction field positions and FSM states.
package alu_issue_pkg;
    localparam int DATA_W  = 4;
    localparam int INSTR_W = 12;
    localparam int REG_AW  = 2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int I_LDI    = 11;
    localparam int I_OP_HI  = 10;
    localparam int I_OP_LO  = 8;
    localparam int I_RD_HI  = 7;
    localparam int I_RD_LO  = 6;
    localparam int I_RS_HI  = 5;
    localparam int I_RS_LO  = 4;
    localparam int I_RT_HI  = 3;
    localparam int I_RT_LO  = 2;
    localparam int I_IMM_HI = 3;
    localparam int I_IMM_LO = 0;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} issue_state_e;

    // The ALU only defines carry/borrow for add and subtract.
    function automatic logic carry_defined(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction
endpackage

// File: rtl/alu_issue_if.sv
// Instruction, response and ALU-side signals of the issue controller.
// master = instruction source / ALU / response sink; slave = the controller.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [2:0]         alu_sel;
    logic [DATA_W-1:0]  alu_out;
    logic               alu_carry;
    logic               alu_zero;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [REG_AW-1:0]  out_rd;
    logic               out_carry;
    logic               out_zero;

    modport master (
        output in_valid, in_instr, out_ready, alu_out, alu_carry, alu_zero,
        input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_rd, out_carry, out_zero
    );
    modport slave (
        input  in_valid, in_instr, out_ready, alu_out, alu_carry, alu_zero,
        output in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_rd, out_carry, out_zero
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Two-entry instruction FIFO; a push into a full FIFO is taken when a pop
// happens in the same cycle.
module alu_cmd_fifo
    import alu_issue_pkg::*;
#(
    parameter int W = INSTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);
    logic [1:0][W-1:0] mem;
    logic              wp, rp;
    logic [1:0]        cnt;
    logic              do_push, do_pop;

    assign empty   = (cnt == 2'd0);
    assign full    = (cnt == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (do_pop) rp <= ~rp;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the 4-bit ALU: register file, operand/opcode registers,
// flag capture and response handshake. ALU_CMD_BUF_EN adds a 2-entry input FIFO.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int NREGS = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_issue_if.slave   bus
);
    issue_state_e                 state, state_nxt;
    logic [NREGS-1:0][DATA_W-1:0] rf;
    logic                         carry_f, zero_f;
    logic [REG_AW-1:0]            rd_q;
    logic                         cmd_valid, accept;
    logic [INSTR_W-1:0]           cmd;
    logic                         is_ldi;
    logic [2:0]                   op;
    logic [REG_AW-1:0]            rd, rs, rt;
    logic [DATA_W-1:0]            imm;
    logic                         carry_nxt;

`ifdef ALU_CMD_BUF_EN
    logic fifo_full, fifo_empty;

    alu_cmd_fifo #(.W(INSTR_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .din   (bus.in_instr),
        .full  (fifo_full),
        .pop   (accept),
        .dout  (cmd),
        .empty (fifo_empty)
    );
    assign cmd_valid    = !fifo_empty;
    assign bus.in_ready = !rst && (!fifo_full || accept);
`else
    assign cmd_valid    = bus.in_valid;
    assign cmd          = bus.in_instr;
    assign bus.in_ready = !rst && (state == S_IDLE);
`endif

    assign accept    = cmd_valid && (state == S_IDLE) && !rst;
    assign is_ldi    = cmd[I_LDI];
    assign op        = cmd[I_OP_HI:I_OP_LO];
    assign rd        = cmd[I_RD_HI:I_RD_LO];
    assign rs        = cmd[I_RS_HI:I_RS_LO];
    assign rt        = cmd[I_RT_HI:I_RT_LO];
    assign imm       = cmd[I_IMM_HI:I_IMM_LO];
    assign carry_nxt = carry_defined(bus.alu_sel) ? bus.alu_carry : carry_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE:    if (accept) state_nxt = is_ldi ? S_RESP : S_ISSUE;
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_RESP;
            S_RESP: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf            <= '0;
            carry_f       <= 1'b0;
            zero_f        <= 1'b0;
            rd_q          <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_sel   <= '0;
            bus.out_data  <= '0;
            bus.out_rd    <= '0;
            bus.out_carry <= 1'b0;
            bus.out_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    if (is_ldi) begin
                        rf[rd]        <= imm;
                        zero_f        <= (imm == '0);
                        bus.out_data  <= imm;
                        bus.out_rd    <= rd;
                        bus.out_carry <= carry_f;
                        bus.out_zero  <= (imm == '0);
                    end else begin
                        bus.alu_a   <= rf[rs];
                        bus.alu_b   <= rf[rt];
                        bus.alu_sel <= op;
                        rd_q        <= rd;
                    end
                end
                // ALU inputs have settled for a full cycle by now.
                S_CAPTURE: begin
                    rf[rd_q]      <= bus.alu_out;
                    zero_f        <= bus.alu_zero;
                    carry_f       <= carry_nxt;
                    bus.out_data  <= bus.alu_out;
                    bus.out_rd    <= rd_q;
                    bus.out_carry <= carry_nxt;
                    bus.out_zero  <= bus.alu_zero;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencer that sits on the operand/opcode side of the 4-bit combinational ALU (alu_4bit).
- Accepts 12-bit instructions over a valid/ready handshake.
- Reads operands from a small register file and drives the ALU's A, B and opcode inputs from registers.
- Captures the result, carry and zero back into the register file and flag registers.
- Returns each completed result over a valid/ready response handshake.

Parameters:
DATA_W, 4, datapath width; must equal the ALU operand width.
NREGS, 4, register file depth; register address width is clog2(NREGS) = 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset; asynchronous, active-high.
in_valid  input  1  instruction valid.
in_ready  output  1  controller can accept an instruction this cycle.
in_instr  input  12  [11] is_ldi, [10:8] op, [7:6] rd, [5:4] rs, [3:2] rt; LDI uses [3:0] as imm.
alu_a  output  DATA_W  ALU operand A, registered.
alu_b  output  DATA_W  ALU operand B, registered.
alu_sel  output  3  ALU opcode, registered.
alu_out  input  DATA_W  ALU result.
alu_carry  input  1  ALU carry/borrow output.
alu_zero  input  1  ALU zero flag.
out_valid  output  1  response valid.
out_ready  input  1  response accepted.
out_data  output  DATA_W  value written to rd.
out_rd  output  2  destination register.
out_carry  output  1  carry flag after the instruction.
out_zero  output  1  zero flag after the instruction.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; all register file entries, flags and outputs clear to 0.
  - in_ready=0 while rst is asserted; in_ready=1 in the first cycle after release.
  - Reset mid-operation abandons the instruction; no response is issued.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - in_ready=1; an instruction is accepted when in_valid & in_ready.
  - ALU instruction: latch alu_a=R[rs], alu_b=R[rt], alu_sel=op, then go to ISSUE.
  - LDI: write R[rd]=imm, set zero=(imm==0), hold carry, load the response registers, then go to RESP.
- ISSUE: one settle cycle for the ALU; go to CAPTURE.
- CAPTURE:
  - R[rd]<=alu_out; zero<=alu_zero.
  - carry<=alu_carry only for op 000 (add) and op 001 (sub); otherwise carry holds its prior value, since the ALU does not define carry for other ops.
  - Load the response registers; go to RESP.
- RESP:
  - out_valid=1; out_* stay stable until out_ready.
  - On the handshake: out_valid drops next cycle and the FSM returns to IDLE.
- Latency, ALU instruction: accept at cycle N, out_valid at N+3. LDI: out_valid at N+1.
- Throughput without the optional feature: one instruction per 4 cycles (ALU) or 2 cycles (LDI) when out_ready=1.
- Operand read:
  - Register reads use the current register file contents.
  - The previous instruction's write is complete before the next accept, so no hazard exists.
  - rs==rt==rd is legal.
- Arithmetic:
  - Subtract wraps mod 16; alu_carry=1 indicates a borrow.
  - Shifts operate on B only; A is ignored.
- alu_a, alu_b and alu_sel hold their last values when idle.

Optional Feature:
Macro ALU_CMD_BUF_EN.
- Defined:
  - Adds a 2-entry instruction FIFO in front of the FSM.
  - in_ready = FIFO not full, independent of FSM state.
  - FSM pops the FIFO when in IDLE.
  - Instructions execute in order.
  - Reset empties the FIFO.
  - Full with a simultaneous pop: a push is accepted in the same cycle.
- Undefined: in_ready = (state==IDLE); no buffer.

Decomposition:
- Package alu_issue_pkg contains:
  - ALU opcode localparams OP_ADD..OP_SHR (000..111).
  - State enum.
  - Instruction field bit positions.
  - DATA_W.
- Sub-module alu_cmd_fifo (2-deep, width 12), instantiated only under ALU_CMD_BUF_EN.
- The register file stays inline.

Test Plan:
- LDI r1=3; LDI r2=5; ADD r3=r1,r2 -> ADD response out_data=8, out_rd=3, carry=0, zero=0, arriving exactly 3 cycles after accept.
- With r1=3, r2=5: SUB r0=r1,r2 -> out_data=4'b1110, carry=1; then AND with r1=4'b1100, r2=4'b1010 -> out_data=4'b1000, carry stays 1.
- XOR r2=r2,r2 -> out_data=0, zero=1, carry unchanged; SHL with rt=4'b0011 -> 4'b0110; SHR with rt=4'b1000 -> 4'b0100.
- Hold out_ready=0 for 5 cycles during RESP -> out_* stable, in_ready=0 without the buffer; with ALU_CMD_BUF_EN, exactly two further instructions are accepted and then in_ready=0.
- Assert rst during ISSUE -> immediately: outputs 0, no response, R[rd] not written; the next LDI/ADD sequence gives correct results.
- Back-to-back ADD r3,r3,r3 with r3=8 -> out_data=0, carry=1, zero=1.
